// File: rtl/jogador_automatico.sv
// jogador_automatico: automatic memory-game player; records the LEDs shown each round and replays them on botoes.
// Optional JOGADOR_ERRO_EN: the last press of round ERRO_RODADA drives the complement of the stored entry.
module jogador_automatico #(
   parameter int MAX_JOGADAS = 16,
   parameter int T_PRESS     = 7,
   parameter int T_GAP       = 7,
   parameter int T_JOGAR     = 2,
   parameter int ERRO_RODADA = 3
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             iniciar,
   input  logic [3:0]                       leds,
   input  logic                             espera,
   input  logic                             ganhou,
   input  logic                             perdeu,
   input  logic                             timeout,
   output logic                             jogar,
   output logic [3:0]                       botoes,
   output logic                             fim,
   output logic [1:0]                       resultado,
   output logic                             erro_captura,
   output logic [2:0]                       db_estado,
   output logic [$clog2(MAX_JOGADAS+1)-1:0] db_tamanho
);
   localparam int CW   = $clog2(MAX_JOGADAS + 1);
   localparam int IW   = (MAX_JOGADAS > 1) ? $clog2(MAX_JOGADAS) : 1;
   localparam int TMAX = (T_PRESS > T_GAP) ? ((T_PRESS > T_JOGAR) ? T_PRESS : T_JOGAR)
                                           : ((T_GAP > T_JOGAR) ? T_GAP : T_JOGAR);
   localparam int TW   = $clog2(TMAX + 1);
   localparam int RW   = 8;
`ifdef JOGADOR_ERRO_EN
   localparam bit ERRO_EN = 1'b1;
`else
   localparam bit ERRO_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      OCIOSO    = 3'b000,
      INICIA    = 3'b001,
      ESCUTA    = 3'b010,
      APAGAR    = 3'b011,
      PRESSIONA = 3'b100,
      SOLTA     = 3'b101,
      FIM       = 3'b110
   } estado_t;

   estado_t       estado_q, estado_d;
   logic [CW-1:0] count_q, count_d, idx_q, idx_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic [RW-1:0] rodada_q, rodada_d;
   logic [3:0]    botoes_q, botoes_d;
   logic [1:0]    res_q, res_d;
   logic          erro_q, erro_d, armado_q, armado_d;
   logic [3:0]    buf_q [MAX_JOGADAS];
   logic          wr_en, carrega, fim_jogo, inj;
   logic [3:0]    press_val;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado_q <= OCIOSO;
         count_q  <= '0;
         idx_q    <= '0;
         tmr_q    <= '0;
         rodada_q <= '0;
         botoes_q <= '0;
         res_q    <= '0;
         erro_q   <= 1'b0;
         armado_q <= 1'b0;
      end else begin
         estado_q <= estado_d;
         count_q  <= count_d;
         idx_q    <= idx_d;
         tmr_q    <= tmr_d;
         rodada_q <= rodada_d;
         botoes_q <= botoes_d;
         res_q    <= res_d;
         erro_q   <= erro_d;
         armado_q <= armado_d;
      end
   end

   // Buffer contents are never read before being rewritten, so no reset is needed.
   always_ff @(posedge clock) begin
      if (wr_en) buf_q[count_q[IW-1:0]] <= leds;
   end

   always_comb begin
      estado_d = estado_q;
      count_d  = count_q;
      idx_d    = idx_q;
      tmr_d    = tmr_q + TW'(1);
      rodada_d = rodada_q;
      botoes_d = botoes_q;
      res_d    = res_q;
      erro_d   = erro_q;
      armado_d = armado_q;
      wr_en    = 1'b0;
      carrega  = 1'b0;
      fim_jogo = (ganhou | perdeu | timeout) && estado_q != OCIOSO && estado_q != FIM;
      if (fim_jogo) begin
         estado_d = FIM;
         botoes_d = '0;
         res_d    = ganhou ? 2'b01 : perdeu ? 2'b10 : 2'b11;
         armado_d = 1'b0;
      end else begin
         case (estado_q)
            OCIOSO: begin
               count_d  = '0;
               rodada_d = '0;
               res_d    = '0;
               tmr_d    = '0;
               if (iniciar) estado_d = INICIA;
            end
            INICIA: if (tmr_q == TW'(T_JOGAR - 1)) estado_d = ESCUTA;
            ESCUTA: begin
               if (leds != 4'd0) begin
                  wr_en    = count_q != CW'(MAX_JOGADAS);
                  erro_d   = erro_q | ~wr_en | (|(leds & (leds - 4'd1)));
                  estado_d = APAGAR;
               end else if (espera && count_q != '0) begin
                  idx_d    = '0;
                  rodada_d = rodada_q + RW'(1);
                  tmr_d    = '0;
                  carrega  = 1'b1;
                  estado_d = PRESSIONA;
               end
            end
            APAGAR: begin
               if (leds == 4'd0) begin
                  count_d  = count_q + CW'(count_q != CW'(MAX_JOGADAS));
                  estado_d = ESCUTA;
               end
            end
            PRESSIONA: begin
               if (tmr_q == TW'(T_PRESS - 1)) begin
                  tmr_d    = '0;
                  botoes_d = '0;
                  estado_d = SOLTA;
               end
            end
            SOLTA: begin
               if (tmr_q == TW'(T_GAP - 1)) begin
                  tmr_d = '0;
                  if (idx_q == count_q - CW'(1)) begin
                     count_d  = '0;
                     estado_d = ESCUTA;
                  end else begin
                     idx_d    = idx_q + CW'(1);
                     carrega  = 1'b1;
                     estado_d = PRESSIONA;
                  end
               end
            end
            FIM: begin
               // A fresh rising iniciar is required to leave, so a held-high request cannot restart.
               armado_d = armado_q | ~iniciar;
               if (armado_q && iniciar) estado_d = OCIOSO;
            end
            default: estado_d = OCIOSO;
         endcase
      end
      press_val = buf_q[idx_d[IW-1:0]];
      inj       = ERRO_EN && rodada_d == RW'(ERRO_RODADA) && idx_d == count_q - CW'(1);
      botoes_d  = carrega ? (inj ? ~press_val : press_val) : botoes_d;
   end

   always_comb begin
      jogar        = estado_q == INICIA;
      fim          = estado_q == FIM;
      botoes       = botoes_q;
      resultado    = res_q;
      erro_captura = erro_q;
      db_estado    = estado_q;
      db_tamanho   = count_q;
   end
endmodule

// File: tb/tb_jogador_automatico.sv
// tb_jogador_automatico: drives jogador_automatico with a scripted memory game and checks presses against the shown sequence.
module tb_jogador_automatico;
   localparam int MAXJ = 16;
   localparam int TP   = 7;
   localparam int TG   = 7;
   localparam int TJ   = 2;
   localparam int ER   = 3;
`ifdef JOGADOR_ERRO_EN
   localparam bit ERRO_EN = 1'b1;
`else
   localparam bit ERRO_EN = 1'b0;
`endif

   logic       clock = 1'b0, reset = 1'b1, iniciar = 1'b0, espera = 1'b0;
   logic       ganhou = 1'b0, perdeu = 1'b0, timeout = 1'b0;
   logic [3:0] leds = 4'd0;
   logic       jogar, fim, erro_captura;
   logic [3:0] botoes;
   logic [1:0] resultado;
   logic [2:0] db_estado;
   logic [4:0] db_tamanho;

   int checks = 0, errors = 0;
   logic [3:0] game_seq[$];
   logic [3:0] exp_q[$];

   typedef struct packed {
      logic       g;
      logic       p;
      logic       t;
      logic [1:0] fase;
      logic [1:0] res;
   } gover_t;
   gover_t tab [7];

   jogador_automatico #(.MAX_JOGADAS(MAXJ), .T_PRESS(TP), .T_GAP(TG), .T_JOGAR(TJ), .ERRO_RODADA(ER)) dut (
      .clock(clock), .reset(reset), .iniciar(iniciar), .leds(leds), .espera(espera),
      .ganhou(ganhou), .perdeu(perdeu), .timeout(timeout), .jogar(jogar), .botoes(botoes),
      .fim(fim), .resultado(resultado), .erro_captura(erro_captura),
      .db_estado(db_estado), .db_tamanho(db_tamanho)
   );

   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic tick();
      @(negedge clock);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic show(input logic [3:0] v, input int on, input int off);
      leds = v;
      for (int i = 0; i < on; i++) begin
         tick();
         if (i == 0) chk("apagar_estado", db_estado, 3);
      end
      leds = 4'd0;
      repeat (off) tick();
   endtask

   task automatic replay();
      espera = 1'b1;
      foreach (exp_q[k]) begin
         for (int i = 0; i < TP; i++) begin
            tick();
            espera = 1'b0;
            chk("press_val", botoes, exp_q[k]);
         end
         for (int i = 0; i < TG; i++) begin
            tick();
            chk("gap_val", botoes, 0);
         end
      end
      tick();
      chk("replay_end_estado", db_estado, 2);
      chk("replay_end_tamanho", db_tamanho, 0);
   endtask

   task automatic start_game();
      int  jc   = 0;
      bit  seen = 1'b0;
      bit  bz   = 1'b1;
      iniciar = 1'b0;
      tick();
      iniciar = 1'b1;
      for (int i = 0; i < 12 && !(seen && db_estado == 3'd2); i++) begin
         tick();
         if (db_estado == 3'd1) seen = 1'b1;
         if (jogar) jc++;
         if (botoes != 4'd0) bz = 1'b0;
      end
      iniciar = 1'b0;
      chk("start_estado", db_estado, 2);
      chk("start_jogar_len", jc, TJ);
      chk("start_botoes_zero", bz, 1);
   endtask

   task automatic play_game(input bit rnd);
      bit lost = 1'b0;
      start_game();
      for (int r = 1; r <= game_seq.size() && !lost; r++) begin
         exp_q = {};
         for (int k = 0; k < r; k++) begin
            show(game_seq[k], rnd ? int'($urandom_range(1, 6)) : 10, rnd ? int'($urandom_range(1, 4)) : 2);
            exp_q.push_back(game_seq[k]);
         end
         chk("round_tamanho", db_tamanho, r);
         if (ERRO_EN && r == ER) begin
            exp_q[r-1] = ~exp_q[r-1];
            lost = 1'b1;
         end
         replay();
      end
      if (lost) perdeu = 1'b1;
      else ganhou = 1'b1;
      tick();
      ganhou = 1'b0;
      perdeu = 1'b0;
      chk("game_fim", fim, 1);
      chk("game_resultado", resultado, lost ? 2'b10 : 2'b01);
      chk("game_botoes", botoes, 0);
   endtask

   initial begin
      logic [3:0] v;
      int n;
      tab[0] = '{1'b1, 1'b0, 1'b0, 2'd0, 2'b01};
      tab[1] = '{1'b0, 1'b1, 1'b0, 2'd1, 2'b10};
      tab[2] = '{1'b0, 1'b0, 1'b1, 2'd2, 2'b11};
      tab[3] = '{1'b1, 1'b1, 1'b0, 2'd1, 2'b01};
      tab[4] = '{1'b0, 1'b1, 1'b1, 2'd0, 2'b10};
      tab[5] = '{1'b1, 1'b1, 1'b1, 2'd2, 2'b01};
      tab[6] = '{1'b0, 1'b0, 1'b1, 2'd1, 2'b11};

      repeat (3) tick();
      chk("rst_estado", db_estado, 0);
      chk("rst_jogar", jogar, 0);
      chk("rst_botoes", botoes, 0);
      chk("rst_fim", fim, 0);
      chk("rst_resultado", resultado, 0);
      chk("rst_erro", erro_captura, 0);
      chk("rst_tamanho", db_tamanho, 0);
      reset = 1'b0;
      tick();
      chk("idle_estado", db_estado, 0);

      iniciar = 1'b1;
      tick();
      chk("inicia_estado1", db_estado, 1);
      chk("inicia_jogar1", jogar, 1);
      tick();
      chk("inicia_estado2", db_estado, 1);
      chk("inicia_jogar2", jogar, 1);
      tick();
      chk("escuta_estado", db_estado, 2);
      chk("escuta_jogar", jogar, 0);
      chk("escuta_botoes", botoes, 0);

      espera = 1'b1;
      repeat (3) tick();
      espera = 1'b0;
      chk("espera_vazio_estado", db_estado, 2);
      chk("espera_vazio_botoes", botoes, 0);

      show(4'b0001, 10, 2);
      chk("one_tamanho", db_tamanho, 1);
      exp_q = {4'b0001};
      replay();

      timeout = 1'b1;
      tick();
      timeout = 1'b0;
      chk("timeout_fim", fim, 1);
      chk("timeout_res", resultado, 2'b11);
      repeat (4) tick();
      chk("fim_hold_iniciar_high", db_estado, 6);
      chk("fim_hold_res", resultado, 2'b11);

      game_seq = {4'b0001, 4'b0100, 4'b1000};
      play_game(1'b0);

      for (int g = 0; g < 4; g++) begin
         game_seq = {};
         n = $urandom_range(3, 6);
         repeat (n) begin
            v = 4'b0001 << $urandom_range(0, 3);
            game_seq.push_back(v);
         end
         play_game(1'b1);
      end

      for (int i = 0; i < 7; i++) begin
         start_game();
         show(4'b0010, 3, 2);
         if (tab[i].fase == 2'd1) begin
            espera = 1'b1;
            repeat (3) tick();
            espera = 1'b0;
            chk("tab_mid_press", botoes, 4'b0010);
         end else if (tab[i].fase == 2'd2) begin
            leds = 4'b0100;
            tick();
         end
         ganhou  = tab[i].g;
         perdeu  = tab[i].p;
         timeout = tab[i].t;
         tick();
         chk("tab_fim", fim, 1);
         chk("tab_res", resultado, tab[i].res);
         chk("tab_botoes", botoes, 0);
         chk("tab_estado", db_estado, 6);
         ganhou  = 1'b0;
         perdeu  = 1'b0;
         timeout = 1'b0;
         leds    = 4'd0;
         repeat (2) tick();
         chk("tab_res_hold", resultado, tab[i].res);
      end

      reset = 1'b1;
      tick();
      reset = 1'b0;
      start_game();
      leds = 4'b0100;
      tick();
      leds = 4'b1000;
      repeat (2) tick();
      leds = 4'd0;
      repeat (2) tick();
      chk("nogap_tamanho", db_tamanho, 1);
      chk("nogap_erro", erro_captura, 0);
      exp_q = {4'b0100};
      for (int i = 1; i < MAXJ; i++) begin
         v = 4'b0001 << $urandom_range(0, 3);
         exp_q.push_back(v);
         show(v, 2, 1);
      end
      chk("full_tamanho", db_tamanho, 16);
      chk("full_erro", erro_captura, 0);
      show(4'b0001, 2, 1);
      chk("ovf_erro", erro_captura, 1);
      chk("ovf_tamanho", db_tamanho, 16);
      replay();
      chk("ovf_erro_sticky", erro_captura, 1);

      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst2_erro", erro_captura, 0);
      start_game();
      show(4'b0011, 3, 1);
      chk("nonhot_erro", erro_captura, 1);
      chk("nonhot_tamanho", db_tamanho, 1);
      show(4'b0001, 3, 1);
      chk("nonhot_sticky", erro_captura, 1);
      chk("nonhot_tamanho2", db_tamanho, 2);
      espera = 1'b1;
      repeat (3) tick();
      espera = 1'b0;
      chk("nonhot_press", botoes, 4'b0011);
      reset = 1'b1;
      #1;
      chk("async_rst_botoes", botoes, 0);
      chk("async_rst_estado", db_estado, 0);
      chk("async_rst_erro", erro_captura, 0);
      tick();
      reset = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/jogador_automatico.md
Name: jogador_automatico

Overview:
- Automatic player that sits on the player side of jogo_desafio_memoria and closes the loop without a human or a bench-scripted player.
- Pulses jogar to start a game and records the one-hot LED sequence the game displays each round.
- When the game waits for input, drives botoes with the recorded sequence using fixed press/release timing.
- Stops when the game reports ganhou, perdeu or timeout; used for board self-test and regression of whole games.

Parameters:
MAX_JOGADAS, 16, capacity of the sequence buffer (entries of 4 bits)
T_PRESS, 7, clock cycles botoes holds a value for each press
T_GAP, 7, clock cycles botoes is held at 0 after each press
T_JOGAR, 2, clock cycles jogar stays high at game start
ERRO_RODADA, 3, round (1-based) on which the optional error injection fires

Ports:
clock  in  1  system clock; all state on the rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
iniciar  in  1  level request to start a game; sampled only in OCIOSO
leds  in  4  game LED output, one-hot while an LED is shown, 0 when dark
espera  in  1  high while the game is waiting for the player
ganhou  in  1  game won
perdeu  in  1  game lost
timeout  in  1  game timed out
jogar  out  1  start pulse to the game
botoes  out  4  button drive to the game
fim  out  1  high in FIM; game over seen
resultado  out  2  latched at FIM: 01 ganhou, 10 perdeu, 11 timeout, 00 none
erro_captura  out  1  sticky: non-one-hot LED captured, or buffer overflow
db_estado  out  3  current state code
db_tamanho  out  $clog2(MAX_JOGADAS+1)  entries captured this round

Behaviour:
- Reset values: jogar=0, botoes=0, fim=0, resultado=00, erro_captura=0, state OCIOSO, capture count=0, replay index=0.
- State codes: OCIOSO 000, INICIA 001, ESCUTA 010, APAGAR 011, PRESSIONA 100, SOLTA 101, FIM 110.
- OCIOSO: when iniciar=1, go to INICIA. Clear the count, the round counter, fim and resultado.
- INICIA: hold jogar=1 for exactly T_JOGAR cycles, then go to ESCUTA with jogar=0.
- ESCUTA: when leds != 0, write leds to buf[count] in that cycle and go to APAGAR.
  - If the captured value is not one-hot, set erro_captura.
  - If count == MAX_JOGADAS, do not write and set erro_captura; count saturates.
- APAGAR: wait for leds == 0. Then increment count (saturating) and return to ESCUTA.
  - A new LED value without an intervening 0 is not a new entry.
- Replay start: in ESCUTA, with leds == 0, espera == 1 and count > 0, set index=0, increment the round counter and go to PRESSIONA.
  - espera with count == 0 is ignored.
- PRESSIONA: botoes = buf[index] for T_PRESS cycles, then go to SOLTA.
- SOLTA: botoes = 0 for T_GAP cycles.
  - If index == count-1, clear count and go to ESCUTA.
  - Otherwise increment index and go to PRESSIONA.
- botoes is registered. It changes only on PRESSIONA entry (to buf[index]) and on SOLTA entry (to 0).
- Game over: ganhou, perdeu or timeout seen in any state other than OCIOSO/FIM goes to FIM on the next edge.
  - In that same transition botoes is forced to 0 and resultado is latched.
  - Priority when several are high together: ganhou > perdeu > timeout.
- FIM: fim=1 and outputs hold. Go to OCIOSO only when iniciar is low for one cycle and then high again; that start passes through OCIOSO into INICIA.
  - This makes a second game without reset possible.
- Reset mid-press: botoes returns to 0 asynchronously; the buffer contents are don't-care and are not read before being rewritten.

Optional Feature:
- Macro JOGADOR_ERRO_EN.
- Defined: on round ERRO_RODADA, the last press of the replay drives the bitwise complement of the stored entry (e.g. 0001 becomes 1110). The game is therefore lost on purpose, exercising the perdeu path.
- Undefined: replay is always exact and ERRO_RODADA is unused.

Test Plan:
- Reset, then iniciar=1 -> jogar high exactly 2 cycles, db_estado 000 -> 001 -> 010, botoes=0 throughout.
- Model shows leds 0001 for 10 cycles, then 0 -> db_tamanho=1. Then espera=1 -> botoes=0001 for 7 cycles, then 0000 for 7 cycles, then count=0, back in ESCUTA.
- Three rounds of sequence 0001, 0100, 1000 -> each press matches the shown order with 7/7 timing. ganhou pulse -> fim=1, resultado=01, botoes=0.
- leds 0011 captured -> erro_captura=1 sticky. 17 LEDs in one round -> erro_captura=1, db_tamanho=16.
- perdeu asserted mid-PRESSIONA -> next edge botoes=0, fim=1, resultado=10. Then iniciar low then high -> jogar pulse and a second game with no reset.
- JOGADOR_ERRO_EN defined, ERRO_RODADA=3 -> last press of round 3 is the complement of the stored entry, then game perdeu -> resultado=10. Undefined -> same stimulus gives ganhou.
